// File: rtl/rv_wb.sv
// rv_wb: RV32I write-back stage (Q104H -> Q105H register-file write).
// Optional build macro RV_WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module rv_wb #(
  parameter int unsigned RSP_TIMEOUT = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_Q104H,
  input  logic        load_Q104H,
  input  logic [2:0]  funct3_Q104H,
  input  logic [1:0]  byte_off_Q104H,
  input  logic [4:0]  rd_Q104H,
  input  logic        reg_wr_en_Q104H,
  input  logic [31:0] pre_wb_data_Q104H,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        ready_Q104H,
  output logic        rf_wr_en_Q105H,
  output logic [4:0]  rf_wr_addr_Q105H,
  output logic [31:0] rf_wr_data_Q105H,
  output logic        err_timeout
`ifdef RV_WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic              completed;
  logic              timed_out;
  logic [31:0]       load_data;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  // Load alignment: byte by full offset, half by offset[1], word unshifted.
  always_comb begin
    sel_byte = dmem_rsp_data[8*byte_off_Q104H +: 8];
    sel_half = byte_off_Q104H[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    case (funct3_Q104H)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = dmem_rsp_data;
    endcase
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_Q104H = 1'b1;
    timed_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_Q104H && load_Q104H && !dmem_rsp_valid) begin
          ready_Q104H = 1'b0;
          state_d     = WAIT_RSP;
          cnt_d       = TO_W'(1);
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_W'(RSP_TIMEOUT)) begin
          timed_out = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          ready_Q104H = 1'b0;
          cnt_d       = cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign completed = valid_Q104H & ready_Q104H;

  always_comb begin
    wr_en_d   = completed & reg_wr_en_Q104H & (rd_Q104H != 5'd0) & ~timed_out;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q | timed_out;
    if (wr_en_d) begin
      wr_addr_d = rd_Q104H;
      wr_data_d = load_Q104H ? load_data : pre_wb_data_Q104H;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rf_wr_en_Q105H   = wr_en_q;
  assign rf_wr_addr_Q105H = wr_addr_q;
  assign rf_wr_data_Q105H = wr_data_q;
  assign err_timeout      = err_q;

`ifdef RV_WB_INSTRET_EN
  logic [63:0] instret_q;

  // Timed-out loads retire too; the counter wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret_q <= '0;
    else if (completed) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_rv_wb.sv
// tb_rv_wb: randomized self-checking bench for rv_wb against a transaction-level model
// (response delay -> stall length, write/timeout outcome, extracted load value).
module tb_rv_wb;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_Q104H, load_Q104H, reg_wr_en_Q104H;
  logic [2:0]  funct3_Q104H;
  logic [1:0]  byte_off_Q104H;
  logic [4:0]  rd_Q104H;
  logic [31:0] pre_wb_data_Q104H;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        ready_Q104H, rf_wr_en_Q105H, err_timeout;
  logic [4:0]  rf_wr_addr_Q105H;
  logic [31:0] rf_wr_data_Q105H;
`ifdef RV_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  rv_wb #(.RSP_TIMEOUT(T), .TO_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_Q104H       (valid_Q104H),
    .load_Q104H        (load_Q104H),
    .funct3_Q104H      (funct3_Q104H),
    .byte_off_Q104H    (byte_off_Q104H),
    .rd_Q104H          (rd_Q104H),
    .reg_wr_en_Q104H   (reg_wr_en_Q104H),
    .pre_wb_data_Q104H (pre_wb_data_Q104H),
    .dmem_rsp_valid    (dmem_rsp_valid),
    .dmem_rsp_data     (dmem_rsp_data),
    .ready_Q104H       (ready_Q104H),
    .rf_wr_en_Q105H    (rf_wr_en_Q105H),
    .rf_wr_addr_Q105H  (rf_wr_addr_Q105H),
    .rf_wr_data_Q105H  (rf_wr_data_Q105H),
    .err_timeout       (err_timeout)
`ifdef RV_WB_INSTRET_EN
    ,
    .instret           (instret)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_err  = 1'b0;
  longint unsigned m_instret = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [31:0]        r;
    sb = 8'(word >> (8 * off));
    sh = 16'(word >> (16 * off[1]));
    case (f3)
      3'b000:  r = 32'(sb);
      3'b001:  r = 32'(sh);
      3'b100:  r = 32'(unsigned'(sb));
      3'b101:  r = 32'(unsigned'(sh));
      default: r = word;
    endcase
    return r;
  endfunction

  task automatic check_outputs(input logic exp_en);
    check("rf_wr_en", rf_wr_en_Q105H, exp_en);
    check("rf_wr_addr", rf_wr_addr_Q105H, m_addr);
    check("rf_wr_data", rf_wr_data_Q105H, m_data);
    check("err_timeout", err_timeout, m_err);
`ifdef RV_WB_INSTRET_EN
    check("instret", instret, m_instret);
`endif
  endtask

  // One instruction; delay = cycle index at which the D_MEM response arrives (> T means never).
  // Entered and left at posedge+1.
  task automatic run_instr(input logic ld, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic we, input logic [31:0] pre,
                           input logic [31:0] word, input int delay);
    int   stall;
    logic writes, to;
    stall  = ld ? ((delay < int'(T)) ? delay : int'(T)) : 0;
    to     = ld && (delay > int'(T));
    writes = !to && we && (rd != 5'd0);
    valid_Q104H = 1'b1; load_Q104H = ld; funct3_Q104H = f3; byte_off_Q104H = off;
    rd_Q104H = rd; reg_wr_en_Q104H = we; pre_wb_data_Q104H = pre;
    for (int k = 0; k <= stall; k++) begin
      dmem_rsp_valid = ld ? (k == delay) : 1'($urandom);
      dmem_rsp_data  = (ld && k == delay) ? word : $urandom;
      @(negedge clk);
      check("ready", ready_Q104H, (k == stall));
      @(posedge clk); #1;
    end
    valid_Q104H = 1'b0; dmem_rsp_valid = 1'b0;
    m_instret++;
    if (to) m_err = 1'b1;
    if (writes) begin
      m_addr = rd;
      m_data = ld ? load_value(f3, off, word) : pre;
    end
    check_outputs(writes);
  endtask

  initial begin
    rst = 1'b0;
    valid_Q104H = 0; load_Q104H = 0; funct3_Q104H = 0; byte_off_Q104H = 0; rd_Q104H = 0;
    reg_wr_en_Q104H = 0; pre_wb_data_Q104H = 0; dmem_rsp_valid = 0; dmem_rsp_data = 0;
    #12;
    check("reset_ready", ready_Q104H, 1'b1);
    check_outputs(1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_instr(0, 3'b000, 2'd0, 5'd5, 1, 32'h0000_1234, 32'h0, 0);
    run_instr(1, 3'b000, 2'd2, 5'd6, 1, 32'h0, 32'h0080_0000, 0);
    run_instr(1, 3'b100, 2'd2, 5'd7, 1, 32'h0, 32'h0080_0000, 0);
    run_instr(1, 3'b001, 2'd2, 5'd8, 1, 32'h0, 32'h8001_7FFF, 3);
    run_instr(1, 3'b010, 2'd1, 5'd0, 1, 32'h0, 32'hDEAD_BEEF, 0);
    run_instr(1, 3'b101, 2'd3, 5'd9, 1, 32'h0, 32'h8001_7FFF, int'(T));
    run_instr(1, 3'b111, 2'd3, 5'd10, 1, 32'h0, 32'h1234_5678, 1);

    // Response while idle with no load is ignored
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_ready", ready_Q104H, 1'b1);
    @(posedge clk); #1; dmem_rsp_valid = 1'b0;
    check_outputs(1'b0);

    // Timeout, then sticky flag across further traffic
    run_instr(1, 3'b010, 2'd0, 5'd11, 1, 32'h0, 32'h0, 99);
    run_instr(0, 3'b000, 2'd0, 5'd12, 1, 32'hCAFE_0001, 32'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom);
      run_instr(1'($urandom), f3, 2'($urandom), 5'($urandom), 1'($urandom),
                $urandom, $urandom, int'($urandom_range(0, T + 2)));
    end

    // Reset asserted while waiting for a response
    valid_Q104H = 1'b1; load_Q104H = 1'b1; funct3_Q104H = 3'b010; rd_Q104H = 5'd3;
    reg_wr_en_Q104H = 1'b1; dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0; #1;
    valid_Q104H = 1'b0; #1;
    m_addr = '0; m_data = '0; m_err = 1'b0; m_instret = 0;
    check("rst_mid_ready", ready_Q104H, 1'b1);
    check_outputs(1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check_outputs(1'b0);
    run_instr(1, 3'b000, 2'd1, 5'd4, 1, 32'h0, 32'h0000_F100, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
